// File: rtl/instr_encoder_pkg.sv
// Shared widths, op-index numbering (also used by the decoder), RV32I major opcodes
// and field-packing helpers for the instruction encoder.
package instr_encoder_pkg;

  localparam int width   = 32;
  localparam int OPWIDTH = 6;

  typedef enum logic [OPWIDTH-1:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE, OP_ECALL, OP_EBREAK,
    OP_RSVD40, OP_RSVD41
  } op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic [2:0] funct3_of(input logic [OPWIDTH-1:0] op);
    logic [2:0] f;
    f = 3'b000;
    case (op)
      OP_BNE, OP_LH, OP_SH, OP_SLLI, OP_SLL:                f = 3'b001;
      OP_LW, OP_SW, OP_SLTI, OP_SLT:                        f = 3'b010;
      OP_SLTIU, OP_SLTU:                                    f = 3'b011;
      OP_BLT, OP_LBU, OP_XORI, OP_XOR:                      f = 3'b100;
      OP_BGE, OP_LHU, OP_SRLI, OP_SRAI, OP_SRL, OP_SRA:     f = 3'b101;
      OP_BLTU, OP_ORI, OP_OR:                               f = 3'b110;
      OP_BGEU, OP_ANDI, OP_AND:                             f = 3'b111;
      default:                                              f = 3'b000;
    endcase
    return f;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction

endpackage

// File: rtl/instr_enc_comb.sv
// Combinational op/fields -> RV32I word plus legality flag.
// Define ENC_RANGE_CHECK_EN to also reject immediates that do not fit their format.
module instr_enc_comb
  import instr_encoder_pkg::*;
(
  input  logic [OPWIDTH-1:0] op,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [31:0]        imm,
  output logic [width-1:0]   word,
  output logic               legal
);

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  logic       i_ok, b_ok, j_ok, sh_ok, u_ok;
  logic [2:0] f3;

  // Sign-extension tests: every bit above the field's sign bit must match it.
  assign i_ok  = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign b_ok  = !imm[0] && ((imm[31:12] == '0) || (imm[31:12] == '1));
  assign j_ok  = !imm[0] && ((imm[31:20] == '0) || (imm[31:20] == '1));
  assign sh_ok = (imm[31:5] == '0);
  assign u_ok  = (imm[31:20] == '0);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    f3    = funct3_of(op);
    case (op)
      OP_LUI: begin
        word  = enc_u(imm[19:0], rd, OPC_LUI);
        legal = !RANGE_CHECK || u_ok;
      end
      OP_AUIPC: begin
        word  = enc_u(imm[19:0], rd, OPC_AUIPC);
        legal = !RANGE_CHECK || u_ok;
      end
      OP_JAL: begin
        word  = enc_j(imm[20:1], rd, OPC_JAL);
        legal = !RANGE_CHECK || j_ok;
      end
      OP_JALR: begin
        word  = enc_i(imm[11:0], rs1, 3'b000, rd, OPC_JALR);
        legal = !RANGE_CHECK || i_ok;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        word  = enc_b(imm[12:1], rs2, rs1, f3, OPC_BRANCH);
        legal = !RANGE_CHECK || b_ok;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        word  = enc_i(imm[11:0], rs1, f3, rd, OPC_LOAD);
        legal = !RANGE_CHECK || i_ok;
      end
      OP_SB, OP_SH, OP_SW: begin
        word  = enc_s(imm[11:0], rs2, rs1, f3, OPC_STORE);
        legal = !RANGE_CHECK || i_ok;
      end
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI: begin
        word  = enc_i(imm[11:0], rs1, f3, rd, OPC_OPIMM);
        legal = !RANGE_CHECK || i_ok;
      end
      OP_SLLI, OP_SRLI: begin
        word  = enc_r(F7_BASE, imm[4:0], rs1, f3, rd, OPC_OPIMM);
        legal = !RANGE_CHECK || sh_ok;
      end
      OP_SRAI: begin
        word  = enc_r(F7_ALT, imm[4:0], rs1, f3, rd, OPC_OPIMM);
        legal = !RANGE_CHECK || sh_ok;
      end
      OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND:
        word = enc_r(F7_BASE, rs2, rs1, f3, rd, OPC_OP);
      OP_SUB, OP_SRA:
        word = enc_r(F7_ALT, rs2, rs1, f3, rd, OPC_OP);
      OP_FENCE:
        word = enc_i({4'b0000, imm[7:0]}, 5'd0, 3'b000, 5'd0, OPC_FENCE);
      OP_ECALL:
        word = enc_i(12'h000, 5'd0, 3'b000, 5'd0, OPC_SYSTEM);
      OP_EBREAK:
        word = enc_i(12'h001, 5'd0, 3'b000, 5'd0, OPC_SYSTEM);
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes op requests into RV32I words, queues them in a 2-entry buffer and tags each
// with an auto-incrementing byte address; rejected requests pulse err and bump err_count.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPWIDTH-1:0] in_op,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [31:0]        in_imm,
  input  logic               restart,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [width-1:0]   out_instr,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               err,
  output logic [7:0]         err_count
);

  logic [width-1:0]  enc_word;
  logic              enc_legal;
  logic [width-1:0]  slot0, slot1;
  logic [1:0]        count;
  logic [ADDR_W-1:0] addr;
  logic              accept, push, pop, reject;

  instr_enc_comb u_enc (
    .op    (in_op),
    .rd    (in_rd),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .imm   (in_imm),
    .word  (enc_word),
    .legal (enc_legal)
  );

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_instr = slot0;
  assign out_addr  = addr;

  assign accept = in_valid && in_ready;
  assign push   = accept && enc_legal;
  assign reject = accept && !enc_legal;
  assign pop    = out_valid && out_ready;

  // slot0 is always the head; a push that coincides with a pop lands directly in slot0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= enc_word;
          else               slot1 <= enc_word;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: slot0 <= enc_word;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        addr <= ADDR_W'(BASE_ADDR);
    else if (restart) addr <= ADDR_W'(BASE_ADDR);
    else if (pop)     addr <= addr + ADDR_W'(4);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err       <= 1'b0;
      err_count <= 8'd0;
    end else begin
      err <= reject;
      if (reject && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule
